// File: rtl/carpark_pkg.sv
// Shared definitions for the car-park gate: generator state encodings,
// command direction codes and the {a,b} sensor patterns the detector decodes.
package carpark_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_PH2  = 3'd2,
    ST_PH3  = 3'd3,
    ST_GAP  = 3'd4
  } gen_state_t;

  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_BOTH = 2'b11;
  localparam logic [1:0] AB_B    = 2'b01;

  // Sensor pattern shown while in a given state for a given direction.
  // An entering car covers the outer sensor first, an exiting car the inner one.
  function automatic logic [1:0] ab_pattern(gen_state_t st, logic dir);
    logic [1:0] ab;
    ab = AB_NONE;
    case (st)
      ST_PH1:  ab = (dir == DIR_EXIT) ? AB_B : AB_A;
      ST_PH2:  ab = AB_BOTH;
      ST_PH3:  ab = (dir == DIR_EXIT) ? AB_A : AB_B;
      default: ab = AB_NONE;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/carpark_sensor_gen_if.sv
// Command/completion bundle between a controller and the sensor generator.
interface carpark_sensor_gen_if;
  logic cmd_valid;
  logic cmd_dir;
  logic cmd_abort;
  logic cmd_ready;
  logic done;
  logic aborted;

  modport master (
    output cmd_valid, cmd_dir, cmd_abort,
    input  cmd_ready, done, aborted
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_abort,
    output cmd_ready, done, aborted
  );
endinterface

// File: rtl/carpark_phase_timer.sv
// Loadable down-counter timing the dwell of each generator state.
// expired is high while the count sits at zero; it then holds at zero.
module carpark_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;

  // Load on state entry, otherwise count down towards zero and stop there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/carpark_sensor_gen.sv
// Turns an enter/exit command into the two-sensor a/b waveform the gate
// detector expects, each phase held for PHASE_CYCLES, followed by a quiet
// gap of GAP_CYCLES and a one-cycle done pulse.
module carpark_sensor_gen
  import carpark_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  carpark_sensor_gen_if.slave   cmd,
  output logic                  a,
  output logic                  b,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  gen_state_t       state_q, state_d;
  logic             dir_q, dir_d;
  logic             abort_q, abort_d;
  logic             done_d, aborted_d;
  logic [1:0]       ab_d;
  logic             accept;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_expired;

  carpark_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign accept        = cmd.cmd_valid && (state_q == ST_IDLE);

  // Next state, latched direction/abort flag, completion strobes and the
  // sensor pattern for the coming cycle; the timer reloads on every state change.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    abort_d   = abort_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_PH1;
          dir_d   = cmd.cmd_dir;
          abort_d = 1'b0;
        end
      end
      ST_PH1, ST_PH2, ST_PH3: begin
        if (cmd.cmd_abort) begin
          state_d = ST_GAP;
          abort_d = 1'b1;
        end else if (timer_expired) begin
          case (state_q)
            ST_PH1:  state_d = ST_PH2;
            ST_PH2:  state_d = ST_PH3;
            default: state_d = ST_GAP;
          endcase
        end
      end
      ST_GAP: begin
        if (timer_expired) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          aborted_d = abort_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ab_d       = ab_pattern(state_d, dir_d);
    timer_load = (state_d != state_q);
    if (state_d == ST_GAP) begin
      timer_val = GAP_LOAD;
    end else if (state_d == ST_IDLE) begin
      timer_val = '0;
    end else begin
      timer_val = PHASE_LOAD;
    end
  end

  // Register state and outputs so a/b change cleanly once per phase boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_ENTER;
      abort_q     <= 1'b0;
      a           <= 1'b0;
      b           <= 1'b0;
      cmd.done    <= 1'b0;
      cmd.aborted <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      abort_q     <= abort_d;
      a           <= ab_d[1];
      b           <= ab_d[0];
      cmd.done    <= done_d;
      cmd.aborted <= aborted_d;
    end
  end

endmodule

// File: tb/tb_carpark_sensor_gen.sv
// Directed bench for the sensor generator: two instances (P=4/G=2 and
// P=1/G=1) share clock and reset; expected per-cycle observations are queued
// when a command is issued and compared cycle by cycle.
module tb_carpark_sensor_gen;
  import carpark_pkg::*;

  typedef struct packed {
    logic [1:0] ab;
    logic       busy;
    logic       ready;
    logic       done;
    logic       aborted;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  logic a4, b4, busy4;
  logic a1, b1, busy1;

  obs_t q4[$];
  obs_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  carpark_sensor_gen_if bus4 ();
  carpark_sensor_gen_if bus1 ();

  carpark_sensor_gen #(.PHASE_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) dut4 (
    .clk(clk), .reset(reset), .cmd(bus4.slave), .a(a4), .b(b4), .busy(busy4)
  );

  carpark_sensor_gen #(.PHASE_CYCLES(1), .GAP_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .cmd(bus1.slave), .a(a1), .b(b1), .busy(busy1)
  );

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  // Enter walks outer->both->inner, exit the reverse.
  function automatic logic [1:0] seq_ab(logic dir, int ph);
    logic [1:0] r;
    case (ph)
      0:       r = dir ? 2'b01 : 2'b10;
      1:       r = 2'b11;
      default: r = dir ? 2'b10 : 2'b01;
    endcase
    return r;
  endfunction

  task automatic pushObs(input int sel, input obs_t e);
    if (sel == 4) q4.push_back(e);
    else          q1.push_back(e);
  endtask

  // Queue the expected cycles following an accept; abort_at is the sequence
  // cycle (1-based) in which abort is held, 0 for none.
  task automatic pushSeq(input int sel, input logic dir, input int abort_at);
    int   p;
    int   g;
    int   last;
    obs_t e;
    p    = (sel == 4) ? 4 : 1;
    g    = (sel == 4) ? 2 : 1;
    last = (abort_at == 0) ? 3 * p : abort_at;
    for (int k = 1; k <= last; k++) begin
      e = '0;
      e.ab   = seq_ab(dir, (k - 1) / p);
      e.busy = 1'b1;
      pushObs(sel, e);
    end
    for (int k = 0; k < g; k++) begin
      e = '0;
      e.busy = 1'b1;
      pushObs(sel, e);
    end
    e = '0;
    e.ready   = 1'b1;
    e.done    = 1'b1;
    e.aborted = (abort_at != 0);
    pushObs(sel, e);
  endtask

  // Compare both instances against their queued expectation for this cycle.
  task automatic checkOutput();
    obs_t o4, o1, e4, e1;
    @(negedge clk);
    cyc++;
    o4 = {a4, b4, busy4, bus4.cmd_ready, bus4.done, bus4.aborted};
    o1 = {a1, b1, busy1, bus1.cmd_ready, bus1.done, bus1.aborted};
    e4 = (q4.size() != 0) ? q4.pop_front() : idle_obs();
    e1 = (q1.size() != 0) ? q1.pop_front() : idle_obs();
    checks++;
    assert (o4 === e4) else begin
      errors++;
      $error("[TB] FAIL dut4 cyc %0d {ab,busy,ready,done,aborted} observed=%b expected=%b", cyc, o4, e4);
    end
    checks++;
    assert (o1 === e1) else begin
      errors++;
      $error("[TB] FAIL dut1 cyc %0d {ab,busy,ready,done,aborted} observed=%b expected=%b", cyc, o1, e1);
    end
  endtask

  // Present a command for one cycle and queue its expected waveform.
  task automatic applyStimulus(input int sel, input logic dir, input int abort_at);
    if (sel == 4) begin
      bus4.cmd_valid = 1'b1;
      bus4.cmd_dir   = dir;
    end else begin
      bus1.cmd_valid = 1'b1;
      bus1.cmd_dir   = dir;
    end
    pushSeq(sel, dir, abort_at);
    checkOutput();
    bus4.cmd_valid = 1'b0;
    bus1.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    while (q4.size() != 0 || q1.size() != 0) checkOutput();
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus4.cmd_valid = 1'b0;
    bus4.cmd_dir   = 1'b0;
    bus4.cmd_abort = 1'b0;
    bus1.cmd_valid = 1'b0;
    bus1.cmd_dir   = 1'b0;
    bus1.cmd_abort = 1'b0;

    $display("[TB] reset state");
    checkOutput();
    checkOutput();
    reset = 1'b0;
    checkOutput();

    $display("[TB] enter P=4 G=2");
    applyStimulus(4, DIR_ENTER, 0);
    drain();
    checkOutput();

    $display("[TB] exit P=1 G=1");
    applyStimulus(1, DIR_EXIT, 0);
    drain();
    checkOutput();

    $display("[TB] back-to-back enter then exit with valid held");
    applyStimulus(4, DIR_ENTER, 0);
    bus4.cmd_valid = 1'b1;
    bus4.cmd_dir   = DIR_EXIT;
    drain();
    pushSeq(4, DIR_EXIT, 0);
    checkOutput();
    bus4.cmd_valid = 1'b0;
    drain();
    checkOutput();

    $display("[TB] abort in second PH2 cycle");
    applyStimulus(4, DIR_ENTER, 6);
    repeat (5) checkOutput();
    bus4.cmd_abort = 1'b1;
    checkOutput();
    bus4.cmd_abort = 1'b0;
    drain();
    checkOutput();

    $display("[TB] abort in PH3 with P=1");
    applyStimulus(1, DIR_EXIT, 3);
    repeat (2) checkOutput();
    bus1.cmd_abort = 1'b1;
    checkOutput();
    bus1.cmd_abort = 1'b0;
    drain();
    checkOutput();

    $display("[TB] ignored abort in idle, with accept, in gap; ignored valid while busy");
    bus4.cmd_abort = 1'b1;
    repeat (2) checkOutput();
    applyStimulus(4, DIR_EXIT, 0);
    bus4.cmd_abort = 1'b0;
    repeat (3) begin
      bus4.cmd_valid = 1'b1;
      bus4.cmd_dir   = DIR_ENTER;
      checkOutput();
      bus4.cmd_valid = 1'b0;
      checkOutput();
    end
    while (q4.size() > 2) checkOutput();
    bus4.cmd_abort = 1'b1;
    checkOutput();
    bus4.cmd_abort = 1'b0;
    drain();
    checkOutput();

    $display("[TB] reset mid-PH3");
    applyStimulus(4, DIR_ENTER, 0);
    repeat (9) checkOutput();
    #2 reset = 1'b1;
    #1;
    checkBit("rst_a", a4, 1'b0);
    checkBit("rst_b", b4, 1'b0);
    checkBit("rst_busy", busy4, 1'b0);
    checkBit("rst_done", bus4.done, 1'b0);
    checkBit("rst_ready", bus4.cmd_ready, 1'b1);
    q4.delete();
    checkOutput();
    reset = 1'b0;
    checkOutput();
    applyStimulus(4, DIR_EXIT, 0);
    drain();
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/carpark_sensor_gen.md
Name: carpark_sensor_gen

Overview:
Sensor-side stimulus generator for the car-park gate. It converts a high-level "car enters" or "car exits" command into the two-sensor waveform on a and b that the gate detector decodes, with a programmable dwell time per phase. It is used in system-level emulation and self-test, driving the detector's a/b inputs directly. A valid/ready command handshake feeds it, and it reports completion with a one-cycle done pulse.

Parameters:
PHASE_CYCLES, 4, cycles each non-idle sensor pattern is held; legal range 1..255
GAP_CYCLES, 2, cycles a=b=0 is held after the last phase (or after an abort) before completion; legal range 1..255
CNT_W, 8, dwell counter width; must hold max(PHASE_CYCLES, GAP_CYCLES)-1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
cmd_valid  in  1  command request
cmd_dir  in  1  0 = enter sequence, 1 = exit sequence; sampled on accept
cmd_ready  out  1  high exactly when state is IDLE
cmd_abort  in  1  abandon the sequence in progress
a  out  1  outer sensor level, registered
b  out  1  inner sensor level, registered
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse, registered
aborted  out  1  qualifies done; high with done when the sequence was aborted

Behaviour:
- Reset, clk and polarity: reset asynchronous, active-high; clock clk. While reset is high, all flops clear. State = IDLE, a=b=0, done=0, aborted=0, counter=0.
- States: IDLE, PH1, PH2, PH3, GAP. cmd_dir is latched into dir_q on accept.
- Patterns {a,b}:
  - Enter: PH1=10, PH2=11, PH3=01.
  - Exit: PH1=01, PH2=11, PH3=10.
  - IDLE and GAP: 00.
- Accept: cmd_valid & cmd_ready at the edge ending cycle n.
  - PH1 pattern appears on a/b in cycles n+1..n+P, PH2 in n+P+1..n+2P, PH3 in n+2P+1..n+3P (P = PHASE_CYCLES).
  - GAP 00 is held in n+3P+1..n+3P+G (G = GAP_CYCLES).
  - State returns to IDLE in cycle n+3P+G+1. In that cycle done=1, aborted=0 and cmd_ready=1.
- Back-to-back: a command accepted in the done cycle starts its PH1 on the next cycle. No extra bubble.
- Counter: loaded with P-1 (or G-1) on each state entry and decremented every cycle. The state advances when the counter is 0. With P=1, each phase lasts exactly 1 cycle.
- a/b are driven from next-state logic into registers: glitch-free, exactly one transition per phase boundary.
- Abort, sampled in PH1/PH2/PH3: the next cycle a=b=0 and state = GAP with a full G-cycle count. It then completes with done=1 and aborted=1.
  - Abort in IDLE or GAP is ignored.
  - Abort in the same cycle as an accept (in IDLE) is ignored; the command runs normally.
- cmd_valid while busy: no effect. cmd_dir is don't-care when not accepted.
- Reset mid-sequence: a/b drop to 00 immediately (asynchronously). No done pulse is produced and the command is lost.
- Illegal state encoding goes to IDLE with a=b=0.

Decomposition:
- Shared package carpark_pkg holds:
  - state encodings for IDLE/PH1/PH2/PH3/GAP;
  - DIR_ENTER=1'b0 and DIR_EXIT=1'b1;
  - sensor pattern constants AB_NONE=2'b00, AB_A=2'b10, AB_BOTH=2'b11, AB_B=2'b01. These are shared with the detector.
- One natural sub-module: carpark_phase_timer.
  - Loadable CNT_W down-counter with ports load, load_val, expired.
  - Instantiated once.

Test Plan:
- Enter, P=4, G=2, accept in cycle 0: a/b = 10 in cycles 1-4, 11 in 5-8, 01 in 9-12, 00 in 13-14; done=1, aborted=0 in cycle 15; cmd_ready low in cycles 1-14. With the gate detector attached, enter pulses in cycle 14 and exit never pulses.
- Exit, P=1, G=1: a/b = 01, 11, 10, 00 on consecutive cycles; done one cycle later; detector exit pulse one cycle after a/b first returns to 00.
- Back-to-back: enter, then exit issued with cmd_valid held high. The second PH1 starts the cycle after the first done. Exactly one enter and one exit pulse from the detector.
- Abort asserted in the second PH2 cycle (P=4, G=2): a/b = 00 the next cycle and for 2 cycles, then done=1 and aborted=1. The detector produces no enter and no exit pulse.
- Reset asserted mid-PH3: a=b=0, busy=0, done=0 immediately. cmd_ready=1 after release and a new command completes normally.
- Ignored inputs: cmd_abort in IDLE, and cmd_valid pulses while busy. No state change, no extra done pulses, a/b sequence unchanged.
